// File: rtl/exec_stage.sv
// Two-stage execute pipeline: S1 latches operands and drives an external ALU,
// S2 captures the result with zero/illegal flags behind a valid/ready handshake.
module exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [3:0]       in_rd,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,

    output logic [3:0]       alu_i,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_rd,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_illegal,

    output logic [15:0]      retire_cnt
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_XNOR = 4'hB
    } op_e;

    logic       v1;
    logic       v2;
    logic [3:0] rd1;
    logic       adv1;
    logic       in_xfer;
    logic       out_xfer;
    logic       op_legal;

    assign adv1      = v1 && (!v2 || out_ready);
    assign in_ready  = !flush && (!v1 || adv1);
    assign in_xfer   = in_valid && in_ready;
    // A flush voids any downstream transfer in the same cycle, so it is not retired.
    assign out_xfer  = v2 && out_ready && !flush;
    assign out_valid = v2;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        op_legal = 1'b0;
        case (alu_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_XNOR: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (in_xfer)
                v1 <= 1'b1;
            else if (adv1)
                v1 <= 1'b0;

            if (adv1)
                v2 <= 1'b1;
            else if (out_xfer)
                v2 <= 1'b0;
        end
    end

    // S1 operand registers feed the ALU directly; they move only on an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_i <= '0;
            alu_a <= '0;
            alu_b <= '0;
            rd1   <= '0;
        end else if (in_xfer) begin
            alu_i <= in_op;
            alu_a <= in_a;
            alu_b <= in_b;
            rd1   <= in_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_rd      <= '0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
        end else if (adv1 && !flush) begin
            out_rd      <= rd1;
            out_result  <= op_legal ? alu_result : '0;
            out_zero    <= op_legal && (alu_result == '0);
            out_illegal <= !op_legal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_cnt <= '0;
        else if (out_xfer)
            retire_cnt <= retire_cnt + 16'd1;
    end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: behavioural ALU, result scoreboard,
// table-driven stream plus hand-written stall, flush, reset and wrap sequences.
module tb_exec_stage;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [3:0]   in_rd;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [3:0]   alu_i;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_result;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_rd;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_illegal;
    logic [15:0]  retire_cnt;

    exec_stage #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_i      (alu_i),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_illegal(out_illegal),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    // External ALU; an illegal opcode returns junk that the DUT must suppress.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        case (alu_i)
            4'h0: alu_result = alu_a + alu_b;
            4'h1: alu_result = alu_a - alu_b;
            4'h8: alu_result = alu_a & alu_b;
            4'h9: alu_result = alu_a | alu_b;
            4'hA: alu_result = alu_a ^ alu_b;
            4'hB: alu_result = ~(alu_a ^ alu_b);
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct packed {
        logic [3:0]   rd;
        logic [W-1:0] res;
        logic         zero;
        logic         ill;
    } exp_t;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zero;
    } vec_t;

    exp_t        sb[$];
    exp_t        next_exp;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_retire = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [3:0] rd,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.rd  = rd;
        e.ill = 1'b0;
        e.res = '0;
        case (op)
            4'h0: e.res = a + b;
            4'h1: e.res = a - b;
            4'h8: e.res = a & b;
            4'h9: e.res = a | b;
            4'hA: e.res = a ^ b;
            4'hB: e.res = ~(a ^ b);
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == '0) && !e.ill;
        return e;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [3:0] rd,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_a     = a;
        in_b     = b;
        next_exp = model(op, rd, a, b);
    endtask

    // Called just after a rising edge; samples handshakes mid-cycle, then
    // advances one edge and updates the scoreboard.
    task automatic tick();
        logic in_fire;
        logic out_fire;
        exp_t got;
        exp_t e;
        #2;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready && !flush;
        got      = {out_rd, out_result, out_zero, out_illegal};
        @(posedge clk);
        #1;
        if (flush) begin
            sb.delete();
        end else begin
            if (out_fire) begin
                exp_retire = exp_retire + 16'd1;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got 0x%0h, expected no output", got);
                end else begin
                    e = sb.pop_front();
                    check("sb_out", 64'(got), 64'(e));
                end
            end
            if (in_fire)
                sb.push_back(next_exp);
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && !out_valid)
                break;
            tick();
        end
        check("drain_empty", 64'(sb.size()), 64'(0));
        check("drain_valid", 64'(out_valid), 64'(0));
    endtask

    task automatic latency_one(input string tag, input logic [3:0] op, input logic [3:0] rd,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] res);
        out_ready = 1'b1;
        drive(op, rd, a, b);
        tick();
        in_valid = 1'b0;
        check({tag, "_valid_n"}, 64'(out_valid), 64'(0));
        tick();
        check({tag, "_valid_n1"}, 64'(out_valid), 64'(1));
        check({tag, "_result"}, 64'(out_result), 64'(res));
        tick();
        check({tag, "_retire"}, 64'(retire_cnt), 64'(exp_retire));
    endtask

    task automatic fill_both();
        out_ready = 1'b0;
        drive(4'h0, 4'd1, 32'd10, 32'd1);
        tick();
        drive(4'h1, 4'd2, 32'd10, 32'd1);
        tick();
        in_valid = 1'b0;
        check("fill_valid", 64'(out_valid), 64'(1));
        check("fill_in_ready", 64'(in_ready), 64'(0));
    endtask

    vec_t                vecs[5];
    logic [3:0]          legal_ops[6];
    logic [W-1:0]        held;
    logic [15:0]         r0;
    int                  acc;
    int                  k;
    int                  n;

    initial begin
        vecs[0] = '{op: 4'h1, a: 32'h2,         b: 32'hA,         res: 32'hFFFF_FFF8, zero: 1'b0};
        vecs[1] = '{op: 4'hB, a: 32'hAAAA_AAAA, b: 32'hDDDD_DDDD, res: 32'h8888_8888, zero: 1'b0};
        vecs[2] = '{op: 4'h8, a: 32'h0,         b: 32'h0,         res: 32'h0,         zero: 1'b1};
        vecs[3] = '{op: 4'h0, a: 32'hFFFF_FFFF, b: 32'h2,         res: 32'h1,         zero: 1'b0};
        vecs[4] = '{op: 4'hA, a: 32'h1234_5678, b: 32'h1234_5678, res: 32'h0,         zero: 1'b1};
        legal_ops = '{4'h0, 4'h1, 4'h8, 4'h9, 4'hA, 4'hB};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_op     = '0;
        in_rd     = '0;
        in_a      = '0;
        in_b      = '0;
        next_exp  = '0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_retire", 64'(retire_cnt), 64'(0));
        check("rst_out_result", 64'(out_result), 64'(0));
        check("rst_alu_a", 64'(alu_a), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        latency_one("add", 4'h0, 4'd3, 32'h5, 32'h5, 32'h0000_000A);

        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].op, 4'(i), vecs[i].a, vecs[i].b);
            next_exp = '{rd: 4'(i), res: vecs[i].res, zero: vecs[i].zero, ill: 1'b0};
            check("stream_in_ready", 64'(in_ready), 64'(1));
            tick();
        end
        drain();

        // Stall: three inputs offered over five cycles with out_ready low.
        r0        = exp_retire;
        out_ready = 1'b0;
        acc       = 0;
        k         = 0;
        held      = '0;
        for (int c = 0; c < 5; c++) begin
            drive(4'h0, 4'(k + 4), 32'(100 * k + 7), 32'(k));
            #1;
            if (c == 3)
                held = out_result;
            if (c == 4)
                check("stall_hold", 64'(out_result), 64'(held));
            if (in_ready) begin
                acc++;
                if (k < 2)
                    k++;
            end
            tick();
        end
        check("stall_accepted", 64'(acc), 64'(2));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        check("stall_result", 64'(out_result), 64'(32'd7));
        drain();
        check("stall_retire", 64'(retire_cnt), 64'(r0 + 16'd2));

        r0 = exp_retire;
        out_ready = 1'b1;
        drive(4'h3, 4'd5, 32'h1234, 32'h1);
        tick();
        in_valid = 1'b0;
        tick();
        check("ill_result", 64'(out_result), 64'(0));
        check("ill_flag", 64'(out_illegal), 64'(1));
        check("ill_zero", 64'(out_zero), 64'(0));
        tick();
        check("ill_retire", 64'(retire_cnt), 64'(r0 + 16'd1));

        fill_both();
        r0 = exp_retire;
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(4'h0, 4'd9, 32'd1, 32'd1);
        check("flush_in_ready", 64'(in_ready), 64'(0));
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'(0));
        tick();
        tick();
        check("flush_dropped", 64'(out_valid), 64'(0));
        check("flush_retire", 64'(retire_cnt), 64'(r0));

        fill_both();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'(0));
        check("arst_retire", 64'(retire_cnt), 64'(0));
        check("arst_result", 64'(out_result), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(1));
        sb.delete();
        exp_retire = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        latency_one("post_rst", 4'h9, 4'd2, 32'hF0, 32'h0F, 32'hFF);

        // Retire-counter wrap: stream up to 0xFFFF, then one more transfer.
        n = 65535 - int'(exp_retire);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive(legal_ops[$urandom_range(0, 5)], 4'(i), 32'($urandom), 32'($urandom));
            tick();
        end
        drain();
        check("wrap_ffff", 64'(retire_cnt), 64'(16'hFFFF));
        drive(4'h0, 4'd1, 32'd1, 32'd2);
        tick();
        drain();
        check("wrap_zero", 64'(retire_cnt), 64'(16'h0000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
